i2c_slave_responder: RTL

//  Synthesizable I2C target (slave) for one bus: the responding end of the IICMB controller's I2C master.

---
 rtl/i2c_slave_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_responder.sv
// I2C target for one bus: matches a 7-bit address, delivers write bytes and fetches
// read bytes through a req/valid handshake, stretching SCL until read data arrives.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h22,
  parameter int         I2C_DATA_WIDTH = 8,
  parameter int         SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_o,
  output logic                      sda_o,
  output logic                      start_o,
  output logic                      op_o,
  output logic                      stop_o,
  output logic                      wr_valid_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      rd_req_o,
  input  logic                      rd_valid_i,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
  output logic                      busy_o,
  output logic [3:0]                state_dbg
);
  localparam int DW = I2C_DATA_WIDTH;

  // Read handshake: a byte moves on a clock edge where rd_req_o and rd_valid_i are
  // both high; rd_req_o drops the cycle after and rd_valid_i is ignored while it is low.
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_WAIT, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic          scl_s, sda_s, scl_q, sda_q;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic          bit_fall, last_bit, addr_match;
  logic          got_bit_q, rw_q;
  logic [2:0]    bit_cnt_q;
  logic [DW-1:0] shift_q;
  logic [DW-2:0] tx_q;
  logic          start_p, stop_p, wr_p;

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_q;
  assign scl_fall   = ~scl_s & scl_q;
  assign start_det  = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det   = scl_s & scl_q & ~sda_q & sda_s;
  // Only a fall that follows a sampled rise ends a bit, so the SCL fall right
  // after START (or after an ACK clock that moved us on) is not counted as data.
  assign bit_fall   = scl_fall & got_bit_q;
  assign last_bit   = (bit_cnt_q == 3'(DW - 1));
  assign addr_match = (shift_q[DW-1:1] == SLAVE_ADDR);
  assign rd_req_o   = (state_q == RD_WAIT);
  assign state_dbg  = state_q;

  always_comb begin
    state_d = state_q;
    start_p = 1'b0;
    stop_p  = 1'b0;
    wr_p    = 1'b0;
    if (stop_det) begin
      state_d = IDLE;
      stop_p  = busy_o;
    end else if (start_det) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        IDLE:     state_d = IDLE;
        ADDR:     if (bit_fall && last_bit) state_d = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (bit_fall) begin
                    start_p = 1'b1;
                    state_d = rw_q ? RD_WAIT : WR_DATA;
                  end
        WR_DATA:  if (bit_fall && last_bit) begin
                    wr_p    = 1'b1;
                    state_d = WR_ACK;
                  end
        WR_ACK:   if (bit_fall) state_d = WR_DATA;
        RD_WAIT:  if (rd_valid_i) state_d = RD_DATA;
        RD_DATA:  if (bit_fall && last_bit) state_d = RD_ACK;
        // shift_q[0] holds the bit the master drove in the acknowledge slot
        RD_ACK:   if (bit_fall) state_d = shift_q[0] ? IGNORE : RD_WAIT;
        IGNORE:   state_d = IGNORE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      scl_sync   <= '1;
      sda_sync   <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      got_bit_q  <= 1'b0;
      rw_q       <= 1'b0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      scl_o      <= 1'b1;
      sda_o      <= 1'b1;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      wr_valid_o <= 1'b0;
      op_o       <= 1'b0;
      wr_data_o  <= '0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync   <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync   <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q      <= scl_s;
      sda_q      <= sda_s;
      start_o    <= start_p;
      stop_o     <= stop_p;
      wr_valid_o <= wr_p;
      // Release lags the handshake by a cycle so the MSB is settled on SDA first
      scl_o      <= (state_q != RD_WAIT);

      if (scl_rise) begin
        got_bit_q <= 1'b1;
        shift_q   <= {shift_q[DW-2:0], sda_s};
      end else if (scl_fall || start_det || stop_det) begin
        got_bit_q <= 1'b0;
      end

      if (start_det || (state_d != state_q)) bit_cnt_q <= '0;
      else if (bit_fall)                     bit_cnt_q <= bit_cnt_q + 3'd1;

      if (wr_p) wr_data_o <= shift_q;

      if (stop_det) begin
        busy_o <= 1'b0;
      end else if (start_p) begin
        busy_o <= 1'b1;
        op_o   <= rw_q;
      end else if (state_q == ADDR && state_d == IGNORE) begin
        busy_o <= 1'b0;
      end

      if (start_det || stop_det) begin
        sda_o <= 1'b1;
      end else begin
        case (state_q)
          ADDR: if (bit_fall && last_bit && addr_match) begin
                  sda_o <= 1'b0;
                  rw_q  <= shift_q[0];
                end
          ADDR_ACK, WR_ACK: if (bit_fall) sda_o <= 1'b1;
          WR_DATA: if (wr_p) sda_o <= 1'b0;
          RD_WAIT: if (rd_valid_i) begin
                     sda_o <= rd_data_i[DW-1];
                     tx_q  <= rd_data_i[DW-2:0];
                   end
          RD_DATA: if (bit_fall) begin
                     sda_o <= last_bit ? 1'b1 : tx_q[DW-2];
                     tx_q  <= {tx_q[DW-3:0], 1'b0};
                   end
          default: sda_o <= 1'b1;
        endcase
      end
    end
  end
endmodule
